// File: rtl/seg7_hex_reader.sv
// Seven-segment scan reader: debounces a multiplexed active-low segment bus and
// assembles the four scanned digits into hex frames behind a valid/ready handshake.
module seg7_hex_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  dig_sel,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] value,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        overrun
);

   typedef enum logic {SCAN, PRESENT} state_t;

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

   state_t      state, state_next;
   logic [6:0]  seg_q, seg_p;
   logic [3:0]  dig_q, dig_p;
   logic [7:0]  cnt;
   logic        same, one_hot, accept;
   logic [3:0]  dec_nib;
   logic        dec_blank, dec_err;
   logic        publish, drop;
   logic [3:0]  seen, seen_next;
   logic [15:0] shadow_value, shadow_value_next;
   logic [3:0]  shadow_blank, shadow_blank_next;
   logic [3:0]  shadow_err, shadow_err_next;

   // Accept fires on the edge where the counter would step onto its saturation value.
   assign same    = ({seg_q, dig_q} == {seg_p, dig_p});
   assign one_hot = (dig_q != 4'h0) && ((dig_q & (dig_q - 4'd1)) == 4'h0);
   assign accept  = same && (cnt == CNT_PRE) && one_hot;

   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (seg_q)
         7'h01: dec_nib = 4'h0;
         7'h4F: dec_nib = 4'h1;
         7'h12: dec_nib = 4'h2;
         7'h06: dec_nib = 4'h3;
         7'h4C: dec_nib = 4'h4;
         7'h24: dec_nib = 4'h5;
         7'h20: dec_nib = 4'h6;
         7'h0F: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h04: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h60: dec_nib = 4'hB;
         7'h31: dec_nib = 4'hC;
         7'h42: dec_nib = 4'hD;
         7'h30: dec_nib = 4'hE;
         7'h38: dec_nib = 4'hF;
         7'h7F: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state;
      publish    = 1'b0;
      drop       = 1'b0;
      case (state)
         SCAN: begin
            if (seen == 4'hF) begin
               publish    = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               state_next = SCAN;
            end else if (seen == 4'hF) begin
               drop = 1'b1;
            end
         end
      endcase
   end

   // A publish or drop empties the shadow set first so a same-cycle accept lands in the new set.
   always_comb begin
      seen_next         = seen;
      shadow_value_next = shadow_value;
      shadow_blank_next = shadow_blank;
      shadow_err_next   = shadow_err;
      if (publish || drop) begin
         seen_next         = 4'h0;
         shadow_value_next = 16'h0000;
         shadow_blank_next = 4'h0;
         shadow_err_next   = 4'h0;
      end
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            if (dig_q[i]) begin
               seen_next[i]              = 1'b1;
               shadow_value_next[4*i +: 4] = dec_nib;
               shadow_blank_next[i]      = dec_blank;
               shadow_err_next[i]        = dec_err;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SCAN;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q        <= 7'h7F;
         dig_q        <= 4'h0;
         seg_p        <= 7'h7F;
         dig_p        <= 4'h0;
         cnt          <= 8'd0;
         seen         <= 4'h0;
         shadow_value <= 16'h0000;
         shadow_blank <= 4'h0;
         shadow_err   <= 4'h0;
         value        <= 16'h0000;
         blank        <= 4'h0;
         err          <= 4'h0;
         overrun      <= 1'b0;
      end else begin
         seg_q <= seg_in;
         dig_q <= dig_sel;
         seg_p <= seg_q;
         dig_p <= dig_q;
         if (!same) begin
            cnt <= 8'd0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
         end
         seen         <= seen_next;
         shadow_value <= shadow_value_next;
         shadow_blank <= shadow_blank_next;
         shadow_err   <= shadow_err_next;
         if (publish) begin
            value <= shadow_value;
            blank <= shadow_blank;
            err   <= shadow_err;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

   assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Bench for seg7_hex_reader: directed frame table, hand-written corner sequences and
// randomized scanning, all checked against a cycle-level behavioural model.
module tb_seg7_hex_reader;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  err;
   logic        overrun;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [6:0] pat_tab [16];

   typedef struct {
      logic [3:0][6:0] pat;
      logic [3:0][3:0] hold;
      logic            exp_valid;
      logic [15:0]     exp_value;
      logic [3:0]      exp_blank;
      logic [3:0]      exp_err;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   seg7_hex_reader #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .seg_in(seg_in),
      .dig_sel(dig_sel),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .value(value),
      .blank(blank),
      .err(err),
      .overrun(overrun)
   );

   // Behavioural model: run length of identical input samples plus per-digit frame arrays.
   logic [10:0] m_last;
   int          m_run;
   logic [3:0]  m_nib [4];
   bit          m_sb [4];
   bit          m_se [4];
   bit          m_seen [4];
   bit          m_pres;
   logic [15:0] m_value;
   logic [3:0]  m_blank;
   logic [3:0]  m_err;
   bit          m_overrun;

   function automatic void decodeRef(input logic [6:0] p, output logic [3:0] n,
                                     output bit b, output bit e);
      n = 4'h0;
      b = (p == 7'h7F);
      e = !b;
      for (int i = 0; i < 16; i++) begin
         if (pat_tab[i] == p) begin
            n = 4'(i);
            e = 1'b0;
         end
      end
   endfunction

   function automatic void clearShadow();
      for (int i = 0; i < 4; i++) begin
         m_seen[i] = 1'b0;
         m_nib[i]  = 4'h0;
         m_sb[i]   = 1'b0;
         m_se[i]   = 1'b0;
      end
   endfunction

   always @(posedge clk) begin
      bit acc;
      bit full;
      if (!rst_n) begin
         m_last    = {7'h7F, 4'h0};
         m_run     = 1;
         m_pres    = 1'b0;
         m_value   = 16'h0000;
         m_blank   = 4'h0;
         m_err     = 4'h0;
         m_overrun = 1'b0;
         clearShadow();
      end else begin
         acc  = (m_run == STABLE) && $onehot(m_last[3:0]);
         full = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
         if (!m_pres && full) begin
            for (int i = 0; i < 4; i++) begin
               m_value[4*i +: 4] = m_nib[i];
               m_blank[i]        = m_sb[i];
               m_err[i]          = m_se[i];
            end
            m_pres = 1'b1;
            clearShadow();
         end else if (m_pres && out_ready) begin
            m_pres = 1'b0;
         end else if (m_pres && full) begin
            m_overrun = 1'b1;
            clearShadow();
         end
         if (acc) begin
            for (int i = 0; i < 4; i++) begin
               if (m_last[i]) begin
                  decodeRef(m_last[10:4], m_nib[i], m_sb[i], m_se[i]);
                  m_seen[i] = 1'b1;
               end
            end
         end
         if ({seg_in, dig_sel} == m_last) begin
            if (m_run <= STABLE) m_run++;
         end else begin
            m_last = {seg_in, dig_sel};
            m_run  = 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic compareModel();
      tests++;
      if ({out_valid, value, blank, err, overrun} !== {m_pres, m_value, m_blank, m_err, m_overrun}) begin
         fails++;
         $display("[TB] FAIL model @%0t: got v=%b val=%h bl=%b er=%b ov=%b expected v=%b val=%h bl=%b er=%b ov=%b",
                  $time, out_valid, value, blank, err, overrun,
                  m_pres, m_value, m_blank, m_err, m_overrun);
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      if (chk_en) compareModel();
   endtask

   task automatic applyStimulus(input vec_t v);
      out_ready = 1'b0;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < int'(v.hold[d]); c++) begin
            seg_in  = v.pat[d];
            dig_sel = 4'(1 << d);
            stepCycle();
         end
      end
      seg_in  = 7'h7F;
      dig_sel = 4'h0;
      repeat (4) stepCycle();
   endtask

   task automatic consumeFrame(input string name);
      out_ready = 1'b1;
      stepCycle();
      out_ready = 1'b0;
      checkOutput({name, "_drop"}, 16'(out_valid), 16'h0);
   endtask

   task automatic checkFrame(input string name, input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
      checkOutput({name, "_valid"}, 16'(out_valid), 16'h1);
      checkOutput({name, "_value"}, value, v);
      checkOutput({name, "_blank"}, 16'(blank), 16'(b));
      checkOutput({name, "_err"}, 16'(err), 16'(e));
   endtask

   initial begin
      vec_t v;
      int   k;
      int   hold;
      int   r;
      logic [6:0] pat;
      logic [3:0] ds;

      pat_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

      vecs[0] = '{pat: {7'h06, 7'h12, 7'h4F, 7'h01}, hold: {4'd4, 4'd4, 4'd4, 4'd4},
                  exp_valid: 1'b1, exp_value: 16'h3210, exp_blank: 4'h0, exp_err: 4'h0};
      vecs[1] = '{pat: {7'h20, 7'h24, 7'h4C, 7'h01}, hold: {4'd4, 4'd4, 4'd4, 4'd3},
                  exp_valid: 1'b0, exp_value: 16'h0000, exp_blank: 4'h0, exp_err: 4'h0};
      vecs[2] = '{pat: {7'h7F, 7'h7F, 7'h7F, 7'h0F}, hold: {4'd0, 4'd0, 4'd0, 4'd4},
                  exp_valid: 1'b1, exp_value: 16'h6547, exp_blank: 4'h0, exp_err: 4'h0};
      vecs[3] = '{pat: {7'h55, 7'h7F, 7'h04, 7'h00}, hold: {4'd4, 4'd4, 4'd4, 4'd4},
                  exp_valid: 1'b1, exp_value: 16'h0098, exp_blank: 4'b0100, exp_err: 4'b1000};
      vecs[4] = '{pat: {7'h42, 7'h31, 7'h60, 7'h08}, hold: {4'd7, 4'd4, 4'd6, 4'd5},
                  exp_valid: 1'b1, exp_value: 16'hDCBA, exp_blank: 4'h0, exp_err: 4'h0};
      vecs[5] = '{pat: {7'h4F, 7'h01, 7'h38, 7'h30}, hold: {4'd4, 4'd4, 4'd4, 4'd4},
                  exp_valid: 1'b1, exp_value: 16'h10FE, exp_blank: 4'h0, exp_err: 4'h0};

      rst_n     = 1'b0;
      seg_in    = 7'h7F;
      dig_sel   = 4'h0;
      out_ready = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      checkOutput("reset_valid", 16'(out_valid), 16'h0);
      checkOutput("reset_value", value, 16'h0000);
      checkOutput("reset_overrun", 16'(overrun), 16'h0);
      stepCycle();
      rst_n = 1'b1;
      stepCycle();

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            checkFrame($sformatf("vec%0d", i), vecs[i].exp_value, vecs[i].exp_blank, vecs[i].exp_err);
            consumeFrame($sformatf("vec%0d", i));
         end
         checkOutput($sformatf("vec%0d_overrun", i), 16'(overrun), 16'h0);
      end

      // Multi-hot select must neither accept nor disturb the partial frame
      v = '{pat: {7'h06, 7'h12, 7'h4F, 7'h01}, hold: {4'd0, 4'd4, 4'd4, 4'd4},
            exp_valid: 1'b0, exp_value: 16'h0, exp_blank: 4'h0, exp_err: 4'h0};
      applyStimulus(v);
      seg_in  = 7'h4C;
      dig_sel = 4'b0011;
      repeat (10) stepCycle();
      seg_in  = 7'h7F;
      dig_sel = 4'h0;
      repeat (4) stepCycle();
      checkOutput("multihot_novalid", 16'(out_valid), 16'h0);
      v.hold = {4'd4, 4'd0, 4'd0, 4'd0};
      applyStimulus(v);
      checkFrame("multihot", 16'h3210, 4'h0, 4'h0);
      consumeFrame("multihot");

      // Two frames without a handshake: first stays, second is dropped
      applyStimulus(vecs[0]);
      checkFrame("ovr_first", 16'h3210, 4'h0, 4'h0);
      checkOutput("ovr_before", 16'(overrun), 16'h0);
      v = '{pat: {7'h0F, 7'h20, 7'h24, 7'h4C}, hold: {4'd4, 4'd4, 4'd4, 4'd4},
            exp_valid: 1'b1, exp_value: 16'h7654, exp_blank: 4'h0, exp_err: 4'h0};
      applyStimulus(v);
      checkFrame("ovr_held", 16'h3210, 4'h0, 4'h0);
      checkOutput("ovr_set", 16'(overrun), 16'h1);
      consumeFrame("ovr");
      checkOutput("ovr_sticky", 16'(overrun), 16'h1);

      // Reset while presenting clears everything on the next cycle
      applyStimulus(vecs[3]);
      checkFrame("rst_pres", 16'h0098, 4'b0100, 4'b1000);
      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      checkOutput("rst_valid", 16'(out_valid), 16'h0);
      checkOutput("rst_value", value, 16'h0000);
      checkOutput("rst_blank", 16'(blank), 16'h0);
      checkOutput("rst_err", 16'(err), 16'h0);
      checkOutput("rst_overrun", 16'(overrun), 16'h0);

      // Reset in the middle of a dwell restarts that dwell
      seg_in  = 7'h01;
      dig_sel = 4'h1;
      repeat (2) stepCycle();
      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      repeat (2) stepCycle();
      v = '{pat: {7'h06, 7'h12, 7'h4F, 7'h01}, hold: {4'd4, 4'd4, 4'd4, 4'd0},
            exp_valid: 1'b0, exp_value: 16'h0, exp_blank: 4'h0, exp_err: 4'h0};
      applyStimulus(v);
      checkOutput("middwell_novalid", 16'(out_valid), 16'h0);
      v.hold = {4'd0, 4'd0, 4'd0, 4'd4};
      applyStimulus(v);
      checkFrame("middwell", 16'h3210, 4'h0, 4'h0);
      consumeFrame("middwell");

      // Randomized scanning against the model
      k = 0;
      while (k < 2500) begin
         hold = $urandom_range(1, 7);
         r    = $urandom_range(0, 19);
         if (r < 14)      pat = pat_tab[$urandom_range(0, 15)];
         else if (r < 17) pat = 7'h7F;
         else             pat = 7'($urandom);
         if ($urandom_range(0, 19) < 17) ds = 4'(1 << $urandom_range(0, 3));
         else                            ds = 4'($urandom);
         for (int c = 0; c < hold; c++) begin
            seg_in    = pat;
            dig_sel   = ds;
            out_ready = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            stepCycle();
            k++;
         end
      end
      rst_n     = 1'b1;
      out_ready = 1'b0;
      repeat (3) stepCycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
